// File: rtl/perm_sequencer.sv
// perm_sequencer: drives a 320-bit round-per-cycle permutation core from a valid/ready request port
// and returns the permuted state on a valid/ready response port, with a bounded wait for the core's done flag.
module perm_sequencer #(
    parameter int W          = 320,
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_state,
    input  logic [4:0]   in_rounds,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_state,
    output logic         err,
    output logic         busy,
    output logic         perm_start,
    output logic [4:0]   perm_ctr,
    output logic [4:0]   perm_rounds,
    output logic [W-1:0] perm_S,
    input  logic [W-1:0] perm_out,
    input  logic         perm_done
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, OUT} state_t;
    localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);
    state_t       state_q, state_d;
    logic [4:0]   ctr_q, ctr_d, rounds_q, rounds_d;
    logic [W-1:0] s_q, s_d, res_q, res_d;
    logic [1:0]   wait_q, wait_d;
    logic         err_q, err_d;
    logic         bad_rounds;
    assign bad_rounds = (in_rounds == 5'd0) || (in_rounds > MAX_R);
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        rounds_d = rounds_q;
        s_d      = s_q;
        res_d    = res_q;
        wait_d   = wait_q;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: if (in_valid) begin
                s_d      = in_state;
                rounds_d = in_rounds;
                ctr_d    = 5'd0;
                err_d    = bad_rounds;
                state_d  = bad_rounds ? IDLE : LOAD;
            end
            LOAD: begin
                ctr_d   = 5'd1;
                state_d = RUN;
            end
            RUN: if (ctr_q == rounds_q) begin
                wait_d  = 2'd0;
                state_d = WAIT;
            end else begin
                ctr_d = ctr_q + 5'd1;
            end
            // four WAIT cycles without done give up with an error pulse
            WAIT: if (perm_done) begin
                res_d   = perm_out;
                state_d = OUT;
            end else if (wait_q == 2'd3) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                wait_d = wait_q + 2'd1;
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ctr_q    <= '0;
            rounds_q <= '0;
            s_q      <= '0;
            res_q    <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            rounds_q <= rounds_d;
            s_q      <= s_d;
            res_q    <= res_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
        end
    end
    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == OUT);
    assign out_state   = res_q;
    assign err         = err_q;
    assign perm_start  = (state_q == LOAD) || (state_q == RUN);
    assign perm_ctr    = ctr_q;
    assign perm_rounds = rounds_q;
    assign perm_S      = s_q;
endmodule

// File: tb/tb_perm_sequencer.sv
// tb_perm_sequencer: randomized bench for perm_sequencer with an Ascon-style core model
// and a reference that applies the last R rounds of the 12-round schedule directly.
module tb_perm_sequencer;
    localparam int W = 320;
    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, stuck = 1'b0;
    logic [W-1:0] in_state = '0, out_state, perm_S, perm_out;
    logic [4:0]   in_rounds = '0, perm_ctr, perm_rounds;
    logic         in_ready, out_valid, err, busy, perm_start, perm_done;
    logic [W-1:0] core_s = '0;
    logic         core_done = 1'b0;
    int checks = 0, failures = 0;

    perm_sequencer #(.W(W), .MAX_ROUNDS(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .in_rounds(in_rounds), .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .err(err), .busy(busy), .perm_start(perm_start), .perm_ctr(perm_ctr),
        .perm_rounds(perm_rounds), .perm_S(perm_S), .perm_out(perm_out), .perm_done(perm_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [W-1:0] ascon_round(input logic [W-1:0] s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ 64'((15 - r) * 16 + r);
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [W-1:0] ref_perm(input logic [W-1:0] s, input int r);
        for (int i = 12 - r; i < 12; i++) s = ascon_round(s, i);
        return s;
    endfunction

    function automatic logic [W-1:0] rnd320();
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < 10; i++) s = {s[W-33:0], 32'($urandom())};
        return s;
    endfunction

    // core model: loads on ctr 0, applies round ctr otherwise, done is registered ctr==rounds
    always @(posedge clk) begin
        if (rst) core_done <= 1'b0;
        else core_done <= (perm_ctr == perm_rounds);
        if (perm_start)
            core_s <= (perm_ctr == 5'd0) ? perm_S
                    : ascon_round(core_s, 12 - int'(perm_rounds) + int'(perm_ctr) - 1);
    end
    assign perm_done = core_done && !stuck;
    assign perm_out  = core_s;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [W-1:0] s, input logic [4:0] r, output int lat,
                          output int low, output int starts, output logic [W-1:0] res);
        in_valid = 1'b1; in_state = s; in_rounds = r;
        cyc();
        in_valid = 1'b0;
        lat = -1; low = 0; starts = 0; res = '0;
        for (int k = 0; k < 64; k++) begin
            if (out_valid && lat < 0) begin lat = k; res = out_state; end
            if (perm_start) starts++;
            if (in_ready) break;
            low++;
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stuck = 1'b0;
        cyc(); cyc();
        checks++; if ({in_ready, out_valid, err, busy, perm_start, perm_ctr, perm_rounds} !== 15'b1_0000_00000_00000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=%b", {in_ready, out_valid, err, busy, perm_start, perm_ctr, perm_rounds}, 15'b1_0000_00000_00000); end
        checks++; if ({out_state, perm_S} !== '0) begin
            failures++; $display("FAIL reset_data got out_state=%h perm_S=%h exp=0", out_state, perm_S); end
        rst = 1'b0; out_ready = 1'b1;
        cyc();
    endtask

    task automatic test_r6_latency();
        int lat, low, st;
        logic [W-1:0] v, res;
        v = 320'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_deadbeefcafef00d;
        do_req(v, 5'd6, lat, low, st, res);
        checks++; if (lat !== 8) begin failures++; $display("FAIL r6_latency got=%0d exp=8", lat); end
        checks++; if (low !== 9) begin failures++; $display("FAIL r6_in_ready_low got=%0d exp=9", low); end
        checks++; if (st !== 7) begin failures++; $display("FAIL r6_start_cycles got=%0d exp=7", st); end
        checks++; if (res !== ref_perm(v, 6)) begin failures++; $display("FAIL r6_result got=%h exp=%h", res, ref_perm(v, 6)); end
        checks++; if (out_state !== res) begin failures++; $display("FAIL r6_out_state_kept got=%h exp=%h", out_state, res); end
    endtask

    task automatic test_back_to_back();
        int lat, low, st;
        logic [W-1:0] s, res;
        do_req('0, 5'd12, lat, low, st, res);
        checks++; if (res !== ref_perm('0, 12)) begin failures++; $display("FAIL p12_zero got=%h exp=%h", res, ref_perm('0, 12)); end
        checks++; if (low !== 15) begin failures++; $display("FAIL p12_in_ready_low got=%0d exp=15", low); end
        s = rnd320();
        do_req(s, 5'd12, lat, low, st, res);
        checks++; if (lat !== 14) begin failures++; $display("FAIL b2b_latency got=%0d exp=14", lat); end
        checks++; if (res !== ref_perm(s, 12)) begin failures++; $display("FAIL b2b_result got=%h exp=%h", res, ref_perm(s, 12)); end
    endtask

    task automatic test_rounds_range();
        int lat, low, st;
        logic [W-1:0] s, res;
        logic [4:0] bad [3];
        s = rnd320();
        do_req(s, 5'd1, lat, low, st, res);
        checks++; if (res !== ref_perm(s, 1) || lat !== 3) begin failures++; $display("FAIL r1 got=%h lat=%0d exp=%h lat=3", res, lat, ref_perm(s, 1)); end
        s = rnd320();
        do_req(s, 5'd12, lat, low, st, res);
        checks++; if (res !== ref_perm(s, 12) || lat !== 14) begin failures++; $display("FAIL r12 got=%h lat=%0d exp=%h lat=14", res, lat, ref_perm(s, 12)); end
        bad[0] = 5'd0; bad[1] = 5'd13; bad[2] = 5'($urandom_range(14, 31));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_state = rnd320(); in_rounds = bad[i];
            cyc();
            in_valid = 1'b0;
            checks++; if ({err, in_ready, out_valid, busy} !== 4'b1100) begin
                failures++; $display("FAIL illegal_err r=%0d got err/rdy/ov/busy=%b exp=1100", bad[i], {err, in_ready, out_valid, busy}); end
            checks++; if (perm_rounds !== bad[i]) begin failures++; $display("FAIL illegal_latch got=%0d exp=%0d", perm_rounds, bad[i]); end
            cyc();
            checks++; if ({err, out_valid, in_ready} !== 3'b001) begin
                failures++; $display("FAIL illegal_pulse r=%0d got err/ov/rdy=%b exp=001", bad[i], {err, out_valid, in_ready}); end
        end
    endtask

    task automatic test_stall();
        int n;
        logic [4:0] r;
        logic [W-1:0] s, held;
        s = rnd320(); r = 5'($urandom_range(1, 12));
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = s; in_rounds = r;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin cyc(); n++; end
        checks++; if (n !== int'(r) + 2) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", n, int'(r) + 2); end
        checks++; if (out_state !== ref_perm(s, int'(r))) begin failures++; $display("FAIL stall_result got=%h exp=%h", out_state, ref_perm(s, int'(r))); end
        held = out_state;
        in_valid = 1'b1; in_state = rnd320(); in_rounds = 5'd5;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++; if ({out_valid, in_ready} !== 2'b10 || out_state !== held || perm_S !== s) begin
                failures++; $display("FAIL stall_hold cyc=%0d got ov/rdy=%b out=%h S=%h", i, {out_valid, in_ready}, out_state, perm_S); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        checks++; if ({out_valid, in_ready} !== 2'b01 || out_state !== held) begin
            failures++; $display("FAIL stall_release got ov/rdy=%b out=%h exp=01 out=%h", {out_valid, in_ready}, out_state, held); end
    endtask

    task automatic test_reset_mid_run();
        int n, lat, low, st;
        logic [W-1:0] s, res;
        in_valid = 1'b1; in_state = rnd320(); in_rounds = 5'd8;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (perm_ctr !== 5'd3 && n < 20) begin cyc(); n++; end
        checks++; if ({perm_start, perm_ctr} !== 6'b1_00011) begin failures++; $display("FAIL run_ctr3 got=%b exp=100011", {perm_start, perm_ctr}); end
        rst = 1'b1;
        cyc();
        checks++; if ({in_ready, out_valid, err, busy, perm_start, perm_ctr, perm_rounds} !== 15'b1_0000_00000_00000) begin
            failures++; $display("FAIL midrst_ctrl got=%b exp=%b", {in_ready, out_valid, err, busy, perm_start, perm_ctr, perm_rounds}, 15'b1_0000_00000_00000); end
        checks++; if ({out_state, perm_S} !== '0) begin
            failures++; $display("FAIL midrst_data got out_state=%h perm_S=%h exp=0", out_state, perm_S); end
        rst = 1'b0;
        s = rnd320();
        do_req(s, 5'd8, lat, low, st, res);
        checks++; if (res !== ref_perm(s, 8) || lat !== 10) begin failures++; $display("FAIL midrst_next got=%h lat=%0d exp=%h lat=10", res, lat, ref_perm(s, 8)); end
    endtask

    task automatic test_done_timeout();
        int n;
        logic seen_ov;
        logic [4:0] r;
        r = 5'($urandom_range(1, 12));
        stuck = 1'b1;
        in_valid = 1'b1; in_state = rnd320(); in_rounds = r;
        cyc();
        in_valid = 1'b0;
        n = 0; seen_ov = 1'b0;
        while (!err && n < 40) begin
            if (out_valid) seen_ov = 1'b1;
            cyc(); n++;
        end
        checks++; if (n !== int'(r) + 5) begin failures++; $display("FAIL timeout_err_cycle got=%0d exp=%0d", n, int'(r) + 5); end
        checks++; if ({seen_ov, out_valid, in_ready, busy} !== 4'b0010) begin
            failures++; $display("FAIL timeout_state got seen_ov/ov/rdy/busy=%b exp=0010", {seen_ov, out_valid, in_ready, busy}); end
        cyc();
        checks++; if ({err, out_valid} !== 2'b00) begin failures++; $display("FAIL timeout_pulse got err/ov=%b exp=00", {err, out_valid}); end
        stuck = 1'b0;
    endtask

    task automatic test_random();
        int lat, low, st;
        logic [4:0] r;
        logic [W-1:0] s, res;
        for (int i = 0; i < 12; i++) begin
            s = rnd320(); r = 5'($urandom_range(1, 12));
            do_req(s, r, lat, low, st, res);
            checks++; if (res !== ref_perm(s, int'(r))) begin failures++; $display("FAIL rand_result r=%0d got=%h exp=%h", r, res, ref_perm(s, int'(r))); end
            checks++; if (lat !== int'(r) + 2 || low !== int'(r) + 3) begin
                failures++; $display("FAIL rand_timing r=%0d got lat=%0d low=%0d exp lat=%0d low=%0d", r, lat, low, int'(r) + 2, int'(r) + 3); end
        end
    endtask

    initial begin
        test_reset();
        test_r6_latency();
        test_back_to_back();
        test_rounds_range();
        test_stall();
        test_reset_mid_run();
        test_done_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end
endmodule
